// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - power-of-two sample decimator feeding a first-word-fall-through FIFO
// Optional box-car averaging when DECIM_AVERAGE_EN is defined; plain last-sample pick otherwise.
module fir_decimator #(
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_RATIO_LOG2  = 4,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         in_valid,
  input  logic [3:0]                   ratio_log2,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FIFO_DEPTH_LOG2:0]     fill,
  output logic                         overflow
);

  localparam int PW    = (MAX_RATIO_LOG2 > 0) ? MAX_RATIO_LOG2 : 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [3:0] RMAX = 4'(MAX_RATIO_LOG2);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  logic [PW-1:0]                phase;
  logic [3:0]                   r_cur;
  logic [3:0]                   r_eff;
  logic [PW:0]                  win_len;
  logic                         win_end;
  logic signed [DATA_WIDTH-1:0] sample_val;
  logic                         prod_valid;
  logic signed [DATA_WIDTH-1:0] prod_data;

  // The ratio only takes effect on the first sample of a window.
  assign r_eff   = (phase == '0) ? ((ratio_log2 > RMAX) ? RMAX : ratio_log2) : r_cur;
  assign win_len = (PW + 1)'(1) << r_eff;
  assign win_end = in_valid && ({1'b0, phase} == win_len - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      r_cur <= '0;
    end else if (in_valid) begin
      if (phase == '0) r_cur <= r_eff;
      phase <= win_end ? '0 : phase + 1'b1;
    end
  end

`ifdef DECIM_AVERAGE_EN
  localparam int AW = DATA_WIDTH + MAX_RATIO_LOG2;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] avg_shift;

  assign acc_next   = (phase == '0) ? AW'(data_in) : acc + AW'(data_in);
  assign avg_shift  = acc_next >>> r_eff;
  assign sample_val = avg_shift[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           acc <= '0;
    else if (in_valid) acc <= acc_next;
  end
`else
  assign sample_val = data_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_valid <= 1'b0;
      prod_data  <= '0;
    end else begin
      prod_valid <= win_end;
      if (win_end) prod_data <= sample_val;
    end
  end

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_next;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       pop;
  logic                       do_write;

  assign out_valid = (count != '0);
  assign fill      = count;
  assign pop       = out_valid && out_ready;
  assign do_write  = prod_valid && ((count != FULL_CNT) || pop);
  assign rd_next   = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= prod_data;
  end

  // data_out is a register so it can hold its last value once the FIFO empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_next;
      case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (prod_valid && !do_write) overflow <= 1'b1;
      if (do_write && (count == '0))
        data_out <= prod_data;
      else if (pop && (count > 1))
        data_out <= $signed(mem[rd_next]);
      else if (pop && do_write)
        data_out <= prod_data;
    end
  end

endmodule
